// File: rtl/addsub_sat_pipe.sv
// addsub_sat_pipe: two-stage pipelined saturating add/sub with valid/ready handshake and retire-time flag register
module addsub_sat_pipe #(
  parameter int WIDTH = 16,
  parameter int LO_W = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             is_sub,
  input  logic             sat_en,
  input  logic             flag_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic [2:0]       res_flag,
  output logic [2:0]       flag
);
  localparam int HI_W = WIDTH - LO_W;
  logic             s1_valid_q, s1_valid_d, c_q, c_d, sat_q, sat_d, fen_q, fen_d;
  logic [LO_W-1:0]  lo_q, lo_d;
  logic [HI_W-1:0]  a_hi_q, a_hi_d, b_hi_q, b_hi_d, hi_sum;
  logic             out_valid_q, out_valid_d, ofen_q, ofen_d;
  logic [WIDTH-1:0] sum_q, sum_d, b_x, res;
  logic [2:0]       rflag_q, rflag_d, flag_q, flag_d;
  logic [LO_W:0]    lo_sum;
  logic             s2_adv, acc, ovf;
  always_comb begin
    b_x = is_sub ? ~b_in : b_in;
    lo_sum = {1'b0, a_in[LO_W-1:0]} + {1'b0, b_x[LO_W-1:0]} + {{LO_W{1'b0}}, is_sub};
    s2_adv = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_adv;
    acc = in_valid && in_ready;
    hi_sum = a_hi_q + b_hi_q + {{(HI_W-1){1'b0}}, c_q};
    ovf = (a_hi_q[HI_W-1] == b_hi_q[HI_W-1]) && (hi_sum[HI_W-1] != a_hi_q[HI_W-1]);
    res = ovf && sat_q ? {a_hi_q[HI_W-1], {(WIDTH-1){~a_hi_q[HI_W-1]}}} : {hi_sum, lo_q};
    s1_valid_d = rst ? 1'b0 : acc ? 1'b1 : s2_adv ? 1'b0 : s1_valid_q;
    lo_d = acc ? lo_sum[LO_W-1:0] : lo_q;
    c_d = acc ? lo_sum[LO_W] : c_q;
    a_hi_d = acc ? a_in[WIDTH-1:LO_W] : a_hi_q;
    b_hi_d = acc ? b_x[WIDTH-1:LO_W] : b_hi_q;
    sat_d = acc ? sat_en : sat_q;
    fen_d = acc ? flag_en : fen_q;
    out_valid_d = rst ? 1'b0 : s2_adv ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    sum_d = rst ? '0 : s2_adv ? res : sum_q;
    rflag_d = rst ? 3'b000 : s2_adv ? {res[WIDTH-1], ovf, res == '0} : rflag_q;
    ofen_d = s2_adv ? fen_q : ofen_q;
    flag_d = rst ? 3'b000 : (out_valid_q && out_ready && ofen_q) ? rflag_q : flag_q;
  end
  always_ff @(posedge clk) begin
    s1_valid_q <= s1_valid_d;
    lo_q <= lo_d;
    c_q <= c_d;
    a_hi_q <= a_hi_d;
    b_hi_q <= b_hi_d;
    sat_q <= sat_d;
    fen_q <= fen_d;
    out_valid_q <= out_valid_d;
    sum_q <= sum_d;
    rflag_q <= rflag_d;
    ofen_q <= ofen_d;
    flag_q <= flag_d;
  end
  assign out_valid = out_valid_q;
  assign sum_out = sum_q;
  assign res_flag = rflag_q;
  assign flag = flag_q;
endmodule

// File: tb/tb_addsub_sat_pipe.sv
// tb_addsub_sat_pipe: vector table, corner sequences and random traffic against a scoreboard
module tb_addsub_sat_pipe;
  typedef struct {
    logic [15:0] a, b;
    logic        sub, sat, fen;
    logic [15:0] es;
    logic [2:0]  ef;
  } vec_t;
  typedef struct {
    logic [15:0] s;
    logic [2:0]  f;
    logic        fen;
  } exp_t;
  logic clk = 1'b0, rst, in_valid, in_ready, is_sub, sat_en, flag_en, out_valid, out_ready;
  logic [15:0] a_in, b_in, sum_out;
  logic [2:0] res_flag, flag;
  logic [2:0] mflag = 3'b000;
  int checks = 0, errors = 0;
  exp_t sbq[$];
  vec_t vecs[11];
  addsub_sat_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .is_sub(is_sub), .sat_en(sat_en), .flag_en(flag_en),
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
    .res_flag(res_flag), .flag(flag)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic sat, input logic fen);
    int sa, sb, r;
    exp_t e;
    sa = $signed(a);
    sb = $signed(b);
    r = sub ? sa - sb : sa + sb;
    e.f[1] = (r > 32767) || (r < -32768);
    e.s = (e.f[1] && sat) ? (r > 0 ? 16'h7fff : 16'h8000) : r[15:0];
    e.f[2] = e.s[15];
    e.f[0] = (e.s == 16'h0000);
    e.fen = fen;
    return e;
  endfunction
  function automatic logic [15:0] pick();
    logic [15:0] c[5];
    c = '{16'h0000, 16'h0001, 16'h7fff, 16'h8000, 16'hffff};
    return ($urandom_range(0, 2) == 0) ? c[$urandom_range(0, 4)] : 16'($urandom);
  endfunction
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic sat,
                      input logic fen, input logic [15:0] es, input logic [2:0] ef, input bit rnd);
    bit acc;
    int t;
    a_in = a; b_in = b; is_sub = sub; sat_en = sat; flag_en = fen; in_valid = 1'b1;
    acc = 0; t = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sbq.push_back(exp_t'{es, ef, fen});
      @(posedge clk); #1;
      t++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout got in_ready=0 for %0d cycles want accept", t);
    end
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    check("flag", flag, mflag);
    if (rst) begin
      sbq.delete();
      mflag = 3'b000;
    end else if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output got %h want none", sum_out);
      end else begin
        e = sbq.pop_front();
        check("sum_out", sum_out, e.s);
        check("res_flag", res_flag, e.f);
        if (e.fen) mflag = e.f;
      end
    end
  end
  initial begin
    exp_t e;
    int t;
    vecs[0]  = '{16'h7fff, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7fff, 3'b010};
    vecs[1]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h8000, 3'b110};
    vecs[2]  = '{16'h7fff, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 3'b110};
    vecs[3]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h0000, 3'b001};
    vecs[4]  = '{16'h00ff, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0100, 3'b000};
    vecs[5]  = '{16'hffff, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hffff, 3'b100};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1, 16'h8000, 3'b110};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 3'b011};
    vecs[8]  = '{16'h0000, 16'h8000, 1'b1, 1'b1, 1'b1, 16'h7fff, 3'b010};
    vecs[9]  = '{16'h00ff, 16'h0100, 1'b1, 1'b0, 1'b1, 16'hffff, 3'b100};
    vecs[10] = '{16'h0080, 16'h0080, 1'b0, 1'b1, 1'b1, 16'h0100, 3'b000};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; is_sub = 1'b0; sat_en = 1'b0; flag_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum_out", sum_out, 0);
    check("rst_res_flag", res_flag, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    send(16'h7fff, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7fff, 3'b010, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_c2_valid", out_valid, 1);
    check("lat_c2_sum", sum_out, 16'h7fff);
    @(posedge clk); #1;
    @(negedge clk);
    check("flag_after_xfer", flag, 3'b010);
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat, vecs[i].fen, vecs[i].es, vecs[i].ef, 0);
      idle(3);
    end
    out_ready = 1'b0;
    send(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0002, 3'b000, 0);
    send(16'h0002, 16'h0002, 1'b0, 1'b1, 1'b1, 16'h0004, 3'b000, 0);
    a_in = 16'h0003; b_in = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_sum", sum_out, 16'h0002);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    if (in_ready) sbq.push_back(exp_t'{16'h0006, 3'b000, 1'b1});
    check("order_0", {out_valid, sum_out}, {1'b1, 16'h0002});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("order_1", {out_valid, sum_out}, {1'b1, 16'h0004});
    @(posedge clk); #1;
    @(negedge clk);
    check("order_2", {out_valid, sum_out}, {1'b1, 16'h0006});
    @(posedge clk); #1;
    idle(2);
    send(16'h7fff, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7fff, 3'b010, 0);
    idle(4);
    check("pre_rst_flag", flag, 3'b010);
    out_ready = 1'b0;
    send(16'h0010, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0011, 3'b000, 0);
    send(16'h0020, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0021, 3'b000, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_flag", flag, 3'b000);
    check("post_rst_sum", sum_out, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a, b;
      logic sub, sat, fen;
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'($urandom_range(0, 1));
        idle(1);
      end
      a = pick(); b = pick();
      sub = 1'($urandom_range(0, 1));
      sat = 1'($urandom_range(0, 1));
      fen = 1'($urandom_range(0, 1));
      e = model(a, b, sub, sat, fen);
      send(a, b, sub, sat, fen, e.s, e.f, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (sbq.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", sbq.size(), 0);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub_sat_pipe.md
Name: addsub_sat_pipe

Overview:
- Parametrised, two-stage pipelined saturating adder/subtractor with a valid/ready handshake on both sides.
- Successor to the single-cycle 16-bit add/sub. Corrects saturation: positive overflow gives max-positive, negative overflow gives max-negative. Corrects the zero flag. Adds a per-op wrap/saturate mode and an architectural flag register updated on retire.
- Sits between the decode/operand stage and the ALU result mux.

Parameters:
- WIDTH, 16, operand/result width. Must be even and ≥4.
- LO_W, WIDTH/2, width of the low half computed in stage 1. The high half, WIDTH-LO_W bits, is computed in stage 2.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  block accepts the operation this cycle
- a_in  input  WIDTH  operand A, two's complement
- b_in  input  WIDTH  operand B, two's complement
- is_sub  input  1  1: A-B, 0: A+B
- sat_en  input  1  1: saturate on overflow, 0: wrap
- flag_en  input  1  op updates the architectural flag register on retire
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- sum_out  output  WIDTH  result
- res_flag  output  3  {N,V,Z} of the presented result
- flag  output  3  architectural flag register {N,V,Z}

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: s1_valid=0, out_valid=0, sum_out=0, res_flag=0, flag=3'b000. In-flight ops are discarded and flag is not updated. rst takes priority over every other event in the same cycle.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - sum_out, res_flag and out_valid are held stable while out_valid && !out_ready.
- Stage 1, on accept:
  - Register the low-half sum of a_in[LO_W-1:0] + b'[LO_W-1:0] + is_sub, where b' = is_sub ? ~b_in : b_in.
  - Register the low-half carry-out, a_in/b' high halves, and is_sub, sat_en, flag_en.
  - Set s1_valid.
- Stage 2:
  - s2_adv = s1_valid && (!out_valid || out_ready).
  - On s2_adv, add the high halves plus the registered carry.
  - Compute V = (a_msb == b'_msb) && (raw_msb != a_msb).
  - If V && sat_en: a_msb=0 gives {0,1...1}; a_msb=1 gives {1,0...0}. Otherwise the raw sum.
  - Register into sum_out and res_flag, and set out_valid=1.
- When out_valid && out_ready && !s2_adv, out_valid clears.
- in_ready = !s1_valid || s2_adv, combinational and with no dependency on in_valid.
- Throughput and latency: one op per cycle sustained. Latency is 2 cycles from accept to out_valid with no backpressure. Capacity is 2 ops; the third is refused (in_ready=0) while the output is stalled.
- Ordering is strictly in-order; there is no drop and no duplication.
- Result flags:
  - Z = (final sum_out == 0).
  - N = final sum_out[WIDTH-1].
  - V = signed overflow, reported regardless of sat_en.
- Architectural flags: on an output transfer with the op's flag_en=1, flag <= res_flag. Otherwise flag holds.
- Simultaneous events: a stage-2 load of a new result and an output transfer in the same cycle are legal. The new result replaces the old and out_valid stays 1.
- Arithmetic is modulo 2^WIDTH before the saturation mux. The carry out of the MSB is ignored. The low-half carry must propagate correctly across the stage boundary.

Test Plan (WIDTH=16, out_ready=1 unless noted):
1. 0x7FFF + 0x0001, sat_en=1, flag_en=1 -> sum_out=0x7FFF, res_flag={N0,V1,Z0} two cycles after accept; flag=3'b010 the cycle after transfer.
2. 0x8000 - 0x0001, sat_en=1 -> 0x8000, {1,1,0}. Then 0x7FFF + 0x0001 with sat_en=0 -> 0x8000 wrapped, {1,1,0}.
3. 0x1234 - 0x1234 -> 0x0000, Z=1. 0x00FF + 0x0001 -> 0x0100, exercising the low-half carry across stages, {0,0,0}. Then an op with flag_en=0 leaves flag unchanged.
4. Back-to-back 0x0001+0x0001, 0x0002+0x0002, 0x0003+0x0003 with out_ready=0 for 4 cycles:
   - in_ready falls after 2 accepts and the third is held by the source.
   - sum_out stays 0x0002.
   - After out_ready=1, results 0x0002, 0x0004, 0x0006 appear in order, one per cycle.
5. Accept 2 ops, assert rst for one cycle while out_valid=1 -> next cycle out_valid=0, in_ready=1, flag=000, and no stale result appears afterward.
6. Random 1000 ops with random in_valid/out_ready against a reference model → sum_out/res_flag match and order is preserved.
